hex_guess_checker: RTL and testbench

Scoring stage placed directly downstream of the two-register hex entry stage in the guessing game. It takes the stored 4-digit guess word and the stored 4-digit secret word, computes Mastermind-style scoring with a small state machine, and reports the results to the display logic. The scoring is exact matches (right digit, right position) and partial matches (right digit, wrong position, duplicates counted once). It also tracks the attempt count and the win/game-over status.

---
 rtl/hex_guess_checker.sv | 140 ++++++++++++++
 tb/tb_hex_guess_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_guess_checker.sv
// Mastermind-style scorer for a 4-digit hex guess against a 4-digit secret, with attempt and win tracking.
// Optional CHECKER_EARLY_EXIT_EN: a 4-exact guess skips the pairing pass and reports two cycles after check.
module hex_guess_checker #(
  parameter int MAX_ATTEMPTS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        check,
  input  logic [15:0] guess,
  input  logic [15:0] actual,
  output logic        busy,
  output logic        done,
  output logic [2:0]  exact,
  output logic [2:0]  partial,
  output logic [3:0]  attempts,
  output logic        win,
  output logic        game_over
);

  localparam logic [3:0] MAX = 4'(MAX_ATTEMPTS);

  typedef enum logic [1:0] {IDLE, EXACT, PAIR, REPORT} state_t;

  state_t      state, next_state;
  logic [15:0] g_q, a_q;
  logic [3:0]  em, gused, aused;
  logic [2:0]  ecount, pcount;
  logic [3:0]  step;           // pairing step: i = step[3:2], j = step[1:0]

  logic        start;
  logic [3:0]  em_next;
  logic [2:0]  ecount_next;
  logic [1:0]  pi, pj;
  logic [3:0]  g_dig, a_dig;
  logic        pair_hit;
  logic [3:0]  att_next;
  logic        win_next, over_next;

  assign busy  = (state != IDLE);
  assign start = (state == IDLE) && check && !game_over && !new_game;

  assign pi    = step[3:2];
  assign pj    = step[1:0];
  assign g_dig = g_q[{pi, 2'b00} +: 4];
  assign a_dig = a_q[{pj, 2'b00} +: 4];
  assign pair_hit = !em[pi] && !em[pj] && !gused[pi] && !aused[pj] && (g_dig == a_dig);

  assign att_next  = (attempts == MAX) ? attempts : attempts + 4'd1;
  assign win_next  = win | (ecount == 3'd4);
  assign over_next = win_next | (att_next == MAX);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    em_next     = '0;
    ecount_next = '0;
    for (int k = 0; k < 4; k++) begin
      em_next[k]  = (g_q[4*k +: 4] == a_q[4*k +: 4]);
      ecount_next = ecount_next + {2'b00, em_next[k]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (start) next_state = EXACT;
`ifdef CHECKER_EARLY_EXIT_EN
      EXACT:  next_state = (ecount_next == 3'd4) ? REPORT : PAIR;
`else
      EXACT:  next_state = PAIR;
`endif
      PAIR:   if (step == 4'd15) next_state = REPORT;
      REPORT: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_q       <= '0;
      a_q       <= '0;
      em        <= '0;
      gused     <= '0;
      aused     <= '0;
      ecount    <= '0;
      pcount    <= '0;
      step      <= '0;
      done      <= 1'b0;
      exact     <= '0;
      partial   <= '0;
      attempts  <= '0;
      win       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (new_game) begin
            attempts  <= '0;
            win       <= 1'b0;
            game_over <= 1'b0;
          end else if (start) begin
            g_q <= guess;
            a_q <= actual;
          end
        end
        EXACT: begin
          em     <= em_next;
          ecount <= ecount_next;
          gused  <= '0;
          aused  <= '0;
          pcount <= '0;
          step   <= '0;
        end
        PAIR: begin
          if (pair_hit) begin
            pcount    <= pcount + 3'd1;
            gused[pi] <= 1'b1;
            aused[pj] <= 1'b1;
          end
          step <= step + 4'd1;
        end
        REPORT: begin
          exact     <= ecount;
          partial   <= pcount;
          attempts  <= att_next;
          win       <= win_next;
          game_over <= over_next;
          done      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_guess_checker.sv
// Self-checking bench for hex_guess_checker: vector table plus reset, saturation and held-check sequences,
// with expected scores queued at issue time and compared when done pulses.
module tb_hex_guess_checker;

`ifdef CHECKER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int MAXA = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_game = 1'b0;
  logic        check_req = 1'b0;
  logic [15:0] guess = '0;
  logic [15:0] actual = '0;
  logic        busy, done, win, game_over;
  logic [2:0]  exact, partial;
  logic [3:0]  attempts;

  hex_guess_checker #(.MAX_ATTEMPTS(MAXA)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .check(check_req),
    .guess(guess), .actual(actual), .busy(busy), .done(done),
    .exact(exact), .partial(partial), .attempts(attempts),
    .win(win), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int ex; int pa; int att; int win; int go; int due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] g; logic [15:0] a; int ex; int pa;
  } vec_t;
  vec_t vecs[12];

  int m_att = 0;
  int m_win = 0;

  function automatic int lat(input int ex);
    return (EARLY && ex == 4) ? 2 : 18;
  endfunction

  // Model of attempt/win bookkeeping; exact/partial come from the hand-derived tables.
  task automatic push_exp(input int ex, input int pa, input int due);
    exp_t e;
    if (m_att < MAXA) m_att++;
    if (ex == 4) m_win = 1;
    e.ex = ex; e.pa = pa; e.att = m_att; e.win = m_win;
    e.go = (m_win != 0 || m_att == MAXA) ? 1 : 0;
    e.due = due;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("exact", int'(exact), e.ex);
        check("partial", int'(partial), e.pa);
        check("attempts", int'(attempts), e.att);
        check("win", int'(win), e.win);
        check("game_over", int'(game_over), e.go);
        check("done_cycle", cyc, e.due);
      end
    end
  end

  task automatic issue(input logic [15:0] g, input logic [15:0] a, input int ex, input int pa);
    @(negedge clk);
    guess = g; actual = a; check_req = 1'b1;
    push_exp(ex, pa, cyc + 1 + lat(ex));
    @(negedge clk);
    check_req = 1'b0;
    check("busy_start", int'(busy), 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      check("done_timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_new_game();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    m_att = 0; m_win = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_exact"}, int'(exact), 0);
    check({tag, "_partial"}, int'(partial), 0);
    check({tag, "_attempts"}, int'(attempts), 0);
    check({tag, "_win"}, int'(win), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
  endtask

  initial begin
    int seen_busy;

    vecs[0]  = '{16'h1234, 16'h1234, 4, 0};
    vecs[1]  = '{16'h4321, 16'h1234, 0, 4};
    vecs[2]  = '{16'h1122, 16'h2211, 0, 4};
    vecs[3]  = '{16'h1111, 16'h1234, 1, 0};
    vecs[4]  = '{16'h0000, 16'hFFFF, 0, 0};
    vecs[5]  = '{16'h1233, 16'h3321, 0, 4};
    vecs[6]  = '{16'hABCD, 16'hABDC, 2, 2};
    vecs[7]  = '{16'h5556, 16'h6555, 2, 2};
    vecs[8]  = '{16'h7000, 16'h0007, 2, 2};
    vecs[9]  = '{16'h1200, 16'h0034, 0, 2};
    vecs[10] = '{16'h9999, 16'h9000, 1, 0};
    vecs[11] = '{16'h0123, 16'h1230, 0, 4};

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Each vector scored as the first guess of a fresh game.
    for (int v = 0; v < 12; v++) begin
      do_new_game();
      issue(vecs[v].g, vecs[v].a, vecs[v].ex, vecs[v].pa);
      wait_idle();
    end

    // Saturation at MAX_ATTEMPTS and refusal of further checks.
    do_new_game();
    check("new_game_attempts", int'(attempts), 0);
    check("new_game_over", int'(game_over), 0);
    for (int k = 0; k < MAXA; k++) begin
      issue(16'h0000, 16'hFFFF, 0, 0);
      wait_idle();
    end
    @(negedge clk); check_req = 1'b1;
    @(negedge clk); check_req = 1'b0;
    seen_busy = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (busy) seen_busy = 1;
    end
    check("busy_after_game_over", seen_busy, 0);
    check("attempts_saturated", int'(attempts), MAXA);
    check("game_over_sticky", int'(game_over), 1);
    do_new_game();
    check("restart_attempts", int'(attempts), 0);
    check("restart_game_over", int'(game_over), 0);

    // Reset in the middle of a score.
    issue(16'h1111, 16'h1234, 1, 0);
    wait_idle();
    @(negedge clk); guess = 16'h4321; actual = 16'h1234; check_req = 1'b1;
    @(negedge clk); check_req = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    m_att = 0; m_win = 0;
    @(negedge clk); reset = 1'b0;
    repeat (25) @(negedge clk);
    issue(16'hABCD, 16'hABDC, 2, 2);
    wait_idle();

    // check held high while busy; operands change mid-score.
    @(negedge clk);
    guess = 16'h4321; actual = 16'h1234; check_req = 1'b1;
    push_exp(0, 4, cyc + 1 + 18);
    push_exp(4, 0, cyc + 1 + 18 + 1 + lat(4));
    repeat (6) @(negedge clk);
    guess = 16'h1234;
    repeat (13) @(negedge clk);
    @(negedge clk); check_req = 1'b0;
    wait_idle();
    check("final_win", int'(win), 1);
    check("final_game_over", int'(game_over), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
